// File: rtl/word_load_sequencer.sv
// word_load_sequencer
//   Assembles bits/byte_bits bytes from a byte stream (little-endian, first
//   byte in the low slice) into one word. When the word is complete it issues
//   a one-cycle load strobe for the downstream word register. It then holds a
//   ready flag until the consumer acknowledges. A partial word is dropped if
//   the gap between bytes reaches timeout_cycles.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   Byte_Valid   in   Byte_In valid this cycle
//   Byte_In      in   incoming byte
//   Word_Ack     in   consumer has taken the stored word
//   Word_Out     out  assembled word (word register Input)
//   Word_Enable  out  one-cycle load strobe (word register Enable)
//   Word_Ready   out  stored word awaiting Word_Ack
//   Overrun      out  one-cycle pulse: byte dropped, no room
//   Timeout      out  one-cycle pulse: partial word discarded
module word_load_sequencer #(
  parameter int bits           = 16,
  parameter int byte_bits      = 8,
  parameter int timeout_cycles = 1000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Byte_Valid,
  input  logic [byte_bits-1:0] Byte_In,
  input  logic                 Word_Ack,
  output logic [bits-1:0]      Word_Out,
  output logic                 Word_Enable,
  output logic                 Word_Ready,
  output logic                 Overrun,
  output logic                 Timeout
);

  localparam int N  = bits / byte_bits;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(timeout_cycles + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COLLECT  = 2'd1;
  localparam logic [1:0] S_LOAD     = 2'd2;
  localparam logic [1:0] S_WAIT_ACK = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [TW-1:0]                   tcnt_q, tcnt_d;
  logic [N-1:0][byte_bits-1:0]     word_q, word_d;
  logic                            en_q, en_d;
  logic                            rdy_q, rdy_d;
  logic                            ovr_q, ovr_d;
  logic                            to_q, to_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    word_d  = word_q;
    en_d    = 1'b0;
    rdy_d   = rdy_q;
    ovr_d   = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Byte_Valid) begin
          word_d[0] = Byte_In;
          cnt_d     = CW'(1);
          tcnt_d    = '0;
          state_d   = (N == 1) ? S_LOAD : S_COLLECT;
          en_d      = (N == 1);
        end
      end

      S_COLLECT: begin
        if (Byte_Valid) begin
          for (int k = 0; k < N; k++)
            if (cnt_q == CW'(k)) word_d[k] = Byte_In;
          cnt_d  = cnt_q + CW'(1);
          tcnt_d = '0;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            state_d = S_LOAD;
            en_d    = 1'b1;
          end
        end else if (tcnt_q == TW'(timeout_cycles - 1)) begin
          // Gap limit hit: drop the partial word, Word_Out keeps stale bytes.
          to_d    = 1'b1;
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      S_LOAD: begin
        state_d = S_WAIT_ACK;
        rdy_d   = 1'b1;
        ovr_d   = Byte_Valid;
      end

      default: begin // S_WAIT_ACK
        if (Word_Ack) begin
          rdy_d   = 1'b0;
          state_d = S_IDLE;
          // A byte arriving with the ack starts the next word immediately.
          if (Byte_Valid) begin
            word_d[0] = Byte_In;
            cnt_d     = CW'(1);
            tcnt_d    = '0;
            state_d   = (N == 1) ? S_LOAD : S_COLLECT;
            en_d      = (N == 1);
          end
        end else begin
          ovr_d = Byte_Valid;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      word_q  <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      word_q  <= word_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign Word_Out    = word_q;
  assign Word_Enable = en_q;
  assign Word_Ready  = rdy_q;
  assign Overrun     = ovr_q;
  assign Timeout     = to_q;

endmodule

// File: tb/tb_word_load_sequencer.sv
module tb_word_load_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Byte_Valid = 1'b0;
  logic        Word_Ack = 1'b0;
  logic [7:0]  Byte_In = '0;

  logic [15:0] wo16;
  logic        en16, rdy16, ov16, to16;
  logic [7:0]  wo8;
  logic        en8, rdy8, ov8, to8;

  always #5 Clk = ~Clk;

  word_load_sequencer #(.bits(16), .byte_bits(8), .timeout_cycles(8)) dut16 (
    .Clk(Clk), .Reset(Reset), .Byte_Valid(Byte_Valid), .Byte_In(Byte_In),
    .Word_Ack(Word_Ack), .Word_Out(wo16), .Word_Enable(en16),
    .Word_Ready(rdy16), .Overrun(ov16), .Timeout(to16));

  word_load_sequencer #(.bits(8), .byte_bits(8), .timeout_cycles(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Byte_Valid(Byte_Valid), .Byte_In(Byte_In),
    .Word_Ack(Word_Ack), .Word_Out(wo8), .Word_Enable(en8),
    .Word_Ready(rdy8), .Overrun(ov8), .Timeout(to8));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: index 0 = 16-bit word (2 bytes), index 1 = 8-bit word.
  // Tracks bytes gathered so far, whether a word is being loaded or is
  // pending, and the idle gap length.
  localparam int T = 8;
  int          nb[2];
  int          idle[2];
  bit          ld[2], rd[2], ov[2], to[2];
  logic [15:0] wexp[2];

  function automatic int nof(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic mreset;
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; idle[i] = 0; ld[i] = 0; rd[i] = 0; ov[i] = 0; to[i] = 0;
      wexp[i] = '0;
    end
  endtask

  task automatic macc(input int i, input logic [7:0] b);
    wexp[i][8*nb[i] +: 8] = b;
    nb[i]++;
    idle[i] = 0;
    if (nb[i] == nof(i)) begin
      ld[i] = 1;
      nb[i] = 0;
    end
  endtask

  task automatic mstep(input bit bv, input logic [7:0] b, input bit ack);
    for (int i = 0; i < 2; i++) begin
      ov[i] = 0;
      to[i] = 0;
      if (ld[i]) begin
        ld[i] = 0;
        rd[i] = 1;
        ov[i] = bv;
      end else if (rd[i]) begin
        if (ack) begin
          rd[i] = 0;
          if (bv) macc(i, b);
        end else begin
          ov[i] = bv;
        end
      end else if (bv) begin
        macc(i, b);
      end else if (nb[i] > 0) begin
        idle[i]++;
        if (idle[i] == T) begin
          to[i] = 1;
          nb[i] = 0;
          idle[i] = 0;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_w16"}, 64'({wo16, en16, rdy16, ov16, to16}),
          64'({wexp[0], ld[0], rd[0], ov[0], to[0]}));
    check({tag, "_w8"}, 64'({wo8, en8, rdy8, ov8, to8}),
          64'({wexp[1][7:0], ld[1], rd[1], ov[1], to[1]}));
  endtask

  // Inputs change right after a falling edge; outputs checked at the next one.
  task automatic tick(input bit bv, input logic [7:0] b, input bit ack);
    Byte_Valid = bv; Byte_In = b; Word_Ack = ack;
    @(posedge Clk);
    mstep(bv, b, ack);
    @(negedge Clk);
    compare("cyc");
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    mreset();
    @(negedge Clk);
    compare("rst");
    Reset = 1'b1;
  endtask

  initial begin
    int mode;
    bit bv, ack;
    mreset();
    @(negedge Clk);
    @(negedge Clk);
    compare("reset");
    check("reset_out", 64'({wo16, en16, rdy16, ov16, to16}), 64'(0));
    Reset = 1'b1;

    // 1: basic two-byte word, then handshake; 3: overrun while pending
    tick(1, 8'h34, 0);
    tick(1, 8'h12, 0);
    check("t1_en", 64'(en16), 64'(1));
    check("t1_word", 64'(wo16), 64'h1234);
    tick(0, 8'h00, 0);
    check("t1_rdy", 64'(rdy16), 64'(1));
    tick(1, 8'h77, 0);
    check("t3_ovr", 64'(ov16), 64'(1));
    check("t3_word", 64'(wo16), 64'h1234);
    tick(0, 8'h00, 1);
    check("t3_rdy0", 64'(rdy16), 64'(0));

    // 2: timeout discards a partial word
    tick(1, 8'h55, 0);
    for (int k = 0; k < T; k++) tick(0, 8'h00, 0);
    check("t2_to", 64'(to16), 64'(1));
    tick(0, 8'h00, 0);
    check("t2_to_once", 64'(to16), 64'(0));
    tick(1, 8'hAA, 0);
    tick(1, 8'hBB, 0);
    check("t2_word", 64'(wo16), 64'hBBAA);
    tick(0, 8'h00, 0);

    // 4: ack and first byte of the next word in the same cycle
    tick(1, 8'h01, 1);
    check("t4_rdy0", 64'(rdy16), 64'(0));
    tick(1, 8'h02, 0);
    check("t4_en", 64'(en16), 64'(1));
    check("t4_word", 64'(wo16), 64'h0201);
    check("t4_novr", 64'(ov16), 64'(0));
    tick(0, 8'h00, 1);
    tick(0, 8'h00, 1);

    // 5: asynchronous reset mid-word
    tick(1, 8'h10, 0);
    #2 Reset = 1'b0;
    #1;
    mreset();
    check("t5_async", 64'({wo16, en16, rdy16, ov16, to16}), 64'(0));
    @(negedge Clk);
    Reset = 1'b1;
    tick(1, 8'h10, 0);
    tick(1, 8'h20, 0);
    check("t5_word", 64'(wo16), 64'h2010);
    tick(0, 8'h00, 1);
    tick(0, 8'h00, 1);

    // 6: single-byte words go straight to the load strobe
    do_reset();
    tick(1, 8'h5A, 0);
    check("t6_en", 64'(en8), 64'(1));
    check("t6_word", 64'(wo8), 64'h5A);
    tick(0, 8'h00, 0);
    check("t6_rdy", 64'(rdy8), 64'(1));
    tick(0, 8'h00, 1);

    // Randomized traffic with busy and sparse phases
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 32 == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        bv  = (mode == 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
        ack = ($urandom_range(0, 99) < 30);
        tick(bv, 8'($urandom), ack);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
